memory_arbiter: RTL and testbench

Shares the single memory-hierarchy port between the instruction-cache miss path and the data-cache miss/writeback path. Each requester holds a `memory_request_t` request until it gets a one-cycle response pulse. The arbiter grants one requester at a time with round-robin priority, forwards the request to memory as a single-cycle pulse, and routes the memory response back to the owner. It sits between `fetch_top`/`instruction_cache`, the data cache, and the memory model in the core top level.

---
 rtl/memory_arbiter.sv | 168 ++++++++++++++++
 tb/tb_memory_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory port between the icache miss path and the
// dcache miss/writeback path; one transaction in flight, request and response pulses registered.

`ifndef ICACHE_LINE_WIDTH
`define ICACHE_LINE_WIDTH 128
`endif

package memory_arbiter_pkg;

    localparam int MEM_LINE_WIDTH = `ICACHE_LINE_WIDTH;

    typedef struct packed {
        logic [31:0]               addr;
        logic                      is_store;
        logic [MEM_LINE_WIDTH-1:0] data;
    } memory_request_t;

endpackage

module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int LINE_WIDTH = `ICACHE_LINE_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  icache_req_valid,
    input  memory_request_t       icache_req_info,
    output logic                  icache_rsp_valid,
    output logic [LINE_WIDTH-1:0] icache_rsp_data,

    input  logic                  dcache_req_valid,
    input  memory_request_t       dcache_req_info,
    output logic                  dcache_rsp_valid,
    output logic [LINE_WIDTH-1:0] dcache_rsp_data,

    output logic                  mem_req_valid,
    output memory_request_t       mem_req_info,
    input  logic                  mem_rsp_valid,
    input  logic [LINE_WIDTH-1:0] mem_rsp_data,

    output logic                  arb_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    localparam logic GRANT_ICACHE = 1'b0;
    localparam logic GRANT_DCACHE = 1'b1;

    state_t                r_state;
    logic                  r_lastGrant;
    logic                  r_owner;
    logic                  r_memReqValid;
    memory_request_t       r_memReqInfo;
    logic                  r_icacheRspValid;
    logic [LINE_WIDTH-1:0] r_icacheRspData;
    logic                  r_dcacheRspValid;
    logic [LINE_WIDTH-1:0] r_dcacheRspData;
    logic                  r_busy;

    logic                  w_anyReq;
    logic                  w_grant;
    memory_request_t       w_grantInfo;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        w_anyReq = icache_req_valid | dcache_req_valid;
        if (icache_req_valid && dcache_req_valid) begin
            w_grant = ~r_lastGrant;
        end else if (dcache_req_valid) begin
            w_grant = GRANT_DCACHE;
        end else begin
            w_grant = GRANT_ICACHE;
        end
        w_grantInfo = (w_grant == GRANT_DCACHE) ? dcache_req_info : icache_req_info;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_lastGrant      <= GRANT_ICACHE;
            r_owner          <= GRANT_ICACHE;
            r_memReqValid    <= 1'b0;
            r_memReqInfo     <= '0;
            r_icacheRspValid <= 1'b0;
            r_icacheRspData  <= '0;
            r_dcacheRspValid <= 1'b0;
            r_dcacheRspData  <= '0;
            r_busy           <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_icacheRspValid <= 1'b0;
                    r_dcacheRspValid <= 1'b0;
                    if (w_anyReq) begin
                        r_owner       <= w_grant;
                        r_lastGrant   <= w_grant;
                        r_memReqInfo  <= w_grantInfo;
                        r_memReqValid <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= S_ISSUE;
                    end else begin
                        r_memReqValid <= 1'b0;
                        r_busy        <= 1'b0;
                    end
                end

                S_ISSUE: begin
                    r_memReqValid <= 1'b0;
                    r_state       <= S_WAIT;
                end

                // The memory line is captured here so the response pulse is purely registered.
                S_WAIT: begin
                    r_memReqValid <= 1'b0;
                    if (mem_rsp_valid) begin
                        if (r_owner == GRANT_DCACHE) begin
                            r_dcacheRspData  <= mem_rsp_data;
                            r_dcacheRspValid <= 1'b1;
                        end else begin
                            r_icacheRspData  <= mem_rsp_data;
                            r_icacheRspValid <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end
                end

                S_RESP: begin
                    r_icacheRspValid <= 1'b0;
                    r_dcacheRspValid <= 1'b0;
                    r_state          <= S_DRAIN;
                end

                // Dead cycle gives the requester time to drop its level request.
                S_DRAIN: begin
                    r_icacheRspValid <= 1'b0;
                    r_dcacheRspValid <= 1'b0;
                    r_busy           <= 1'b0;
                    r_state          <= S_IDLE;
                end

                default: begin
                    r_memReqValid    <= 1'b0;
                    r_icacheRspValid <= 1'b0;
                    r_dcacheRspValid <= 1'b0;
                    r_busy           <= 1'b0;
                    r_state          <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req_valid    = r_memReqValid;
    assign mem_req_info     = r_memReqInfo;
    assign icache_rsp_valid = r_icacheRspValid;
    assign icache_rsp_data  = r_icacheRspData;
    assign dcache_rsp_valid = r_dcacheRspValid;
    assign dcache_rsp_data  = r_dcacheRspData;
    assign arb_busy         = r_busy;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: each task drives one scenario cycle by cycle
// and compares outputs against hand-derived values one cycle at a time.

module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int LW = MEM_LINE_WIDTH;
    localparam logic [LW-1:0] PAT_A5   = {(LW/8){8'hA5}};
    localparam logic [LW-1:0] PAT_1234 = {(LW/16){16'h1234}};
    localparam logic [LW-1:0] PAT_BEEF = {(LW/16){16'hBEEF}};
    localparam logic [LW-1:0] PAT_5A   = {(LW/8){8'h5A}};
    localparam logic [LW-1:0] PAT_3C   = {(LW/8){8'h3C}};
    localparam logic [LW-1:0] PAT_77   = {(LW/8){8'h77}};

    logic            clock = 1'b0;
    logic            reset;
    logic            icache_req_valid;
    memory_request_t icache_req_info;
    logic            icache_rsp_valid;
    logic [LW-1:0]   icache_rsp_data;
    logic            dcache_req_valid;
    memory_request_t dcache_req_info;
    logic            dcache_rsp_valid;
    logic [LW-1:0]   dcache_rsp_data;
    logic            mem_req_valid;
    memory_request_t mem_req_info;
    logic            mem_rsp_valid;
    logic [LW-1:0]   mem_rsp_data;
    logic            arb_busy;

    int total = 0;
    int bad   = 0;
    int icRspCount  = 0;
    int dcRspCount  = 0;
    int memReqCount = 0;

    memory_arbiter #(.LINE_WIDTH(LW)) dut (
        .clock           (clock),
        .reset           (reset),
        .icache_req_valid(icache_req_valid),
        .icache_req_info (icache_req_info),
        .icache_rsp_valid(icache_rsp_valid),
        .icache_rsp_data (icache_rsp_data),
        .dcache_req_valid(dcache_req_valid),
        .dcache_req_info (dcache_req_info),
        .dcache_rsp_valid(dcache_rsp_valid),
        .dcache_rsp_data (dcache_rsp_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_info    (mem_req_info),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .arb_busy        (arb_busy)
    );

    always #5 clock = ~clock;

    // Pulse counters sampled mid-cycle, used to prove pulses are single and routed correctly.
    always @(negedge clock) begin
        if (icache_rsp_valid === 1'b1) icRspCount++;
        if (dcache_rsp_valid === 1'b1) dcRspCount++;
        if (mem_req_valid === 1'b1) memReqCount++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clearInputs();
        icache_req_valid = 1'b0;
        icache_req_info  = '0;
        dcache_req_valid = 1'b0;
        dcache_req_info  = '0;
        mem_rsp_valid    = 1'b0;
        mem_rsp_data     = '0;
    endtask

    task automatic doReset();
        clearInputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic memory_request_t mkReq(logic [31:0] addr, logic st, logic [LW-1:0] data);
        memory_request_t r;
        r.addr     = addr;
        r.is_store = st;
        r.data     = data;
        return r;
    endfunction

    task automatic test_reset();
        clearInputs();
        reset = 1'b1;
        tick();
        tick();
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_req_valid got=%b want=0", mem_req_valid); end
        total++; if (icache_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_icache_rsp_valid got=%b want=0", icache_rsp_valid); end
        total++; if (dcache_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_dcache_rsp_valid got=%b want=0", dcache_rsp_valid); end
        total++; if (arb_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_arb_busy got=%b want=0", arb_busy); end
        total++; if (mem_req_info !== '0) begin bad++; $display("[TB] FAIL reset_mem_req_info got=%h want=0", mem_req_info); end
        total++; if (icache_rsp_data !== '0) begin bad++; $display("[TB] FAIL reset_icache_rsp_data got=%h want=0", icache_rsp_data); end
        total++; if (dcache_rsp_data !== '0) begin bad++; $display("[TB] FAIL reset_dcache_rsp_data got=%h want=0", dcache_rsp_data); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_icache();
        int ic0, dc0, mr0;
        ic0 = icRspCount; dc0 = dcRspCount; mr0 = memReqCount;
        icache_req_valid = 1'b1;
        icache_req_info  = mkReq(32'h1000, 1'b0, '0);
        tick();
        total++; if (mem_req_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_issue_valid got=%b want=1", mem_req_valid); end
        total++; if (mem_req_info.addr !== 32'h1000) begin bad++; $display("[TB] FAIL single_issue_addr got=%h want=00001000", mem_req_info.addr); end
        total++; if (mem_req_info.is_store !== 1'b0) begin bad++; $display("[TB] FAIL single_issue_store got=%b want=0", mem_req_info.is_store); end
        total++; if (arb_busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy got=%b want=1", arb_busy); end
        tick();
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_req_one_cycle got=%b want=0", mem_req_valid); end
        tick();
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = PAT_A5;
        tick();
        total++; if (icache_rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_rsp_valid got=%b want=1", icache_rsp_valid); end
        total++; if (icache_rsp_data !== PAT_A5) begin bad++; $display("[TB] FAIL single_rsp_data got=%h want=%h", icache_rsp_data, PAT_A5); end
        mem_rsp_valid    = 1'b0;
        mem_rsp_data     = '0;
        icache_req_valid = 1'b0;
        tick();
        total++; if (icache_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_rsp_one_cycle got=%b want=0", icache_rsp_valid); end
        tick();
        total++; if (arb_busy !== 1'b0) begin bad++; $display("[TB] FAIL single_idle_busy got=%b want=0", arb_busy); end
        total++; if (icRspCount - ic0 !== 1) begin bad++; $display("[TB] FAIL single_ic_pulses got=%0d want=1", icRspCount - ic0); end
        total++; if (dcRspCount - dc0 !== 0) begin bad++; $display("[TB] FAIL single_dc_pulses got=%0d want=0", dcRspCount - dc0); end
        total++; if (memReqCount - mr0 !== 1) begin bad++; $display("[TB] FAIL single_mem_pulses got=%0d want=1", memReqCount - mr0); end
    endtask

    task automatic test_tie();
        int n;
        doReset();
        icache_req_valid = 1'b1;
        icache_req_info  = mkReq(32'h2000, 1'b0, '0);
        dcache_req_valid = 1'b1;
        dcache_req_info  = mkReq(32'h3000, 1'b0, '0);
        tick();
        total++; if (mem_req_info.addr !== 32'h3000) begin bad++; $display("[TB] FAIL tie_first_addr got=%h want=00003000", mem_req_info.addr); end
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = PAT_77;
        tick();
        total++; if (dcache_rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL tie_dc_rsp got=%b want=1", dcache_rsp_valid); end
        total++; if (icache_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL tie_ic_quiet got=%b want=0", icache_rsp_valid); end
        mem_rsp_valid    = 1'b0;
        dcache_req_valid = 1'b0;
        n = 1;
        while (mem_req_valid !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        total++; if (n !== 4) begin bad++; $display("[TB] FAIL tie_second_latency got=%0d want=4", n); end
        total++; if (mem_req_info.addr !== 32'h2000) begin bad++; $display("[TB] FAIL tie_second_addr got=%h want=00002000", mem_req_info.addr); end
        tick();
        mem_rsp_valid = 1'b1;
        tick();
        total++; if (icache_rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL tie_ic_rsp got=%b want=1", icache_rsp_valid); end
        mem_rsp_valid    = 1'b0;
        dcache_req_valid = 1'b1;
        tick();
        tick();
        tick();
        total++; if (mem_req_info.addr !== 32'h3000 || mem_req_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL tie_repeat got=%h/%b want=00003000/1", mem_req_info.addr, mem_req_valid);
        end
        doReset();
    endtask

    task automatic test_writeback();
        memory_request_t exp;
        exp = mkReq(32'h4000, 1'b1, PAT_1234);
        doReset();
        dcache_req_valid = 1'b1;
        dcache_req_info  = exp;
        tick();
        total++; if (mem_req_valid !== 1'b1) begin bad++; $display("[TB] FAIL wb_issue got=%b want=1", mem_req_valid); end
        total++; if (mem_req_info !== exp) begin bad++; $display("[TB] FAIL wb_info got=%h want=%h", mem_req_info, exp); end
        dcache_req_info.data = ~PAT_1234;
        tick();
        total++; if (mem_req_info !== exp) begin bad++; $display("[TB] FAIL wb_info_latched got=%h want=%h", mem_req_info, exp); end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = PAT_BEEF;
        tick();
        total++; if (dcache_rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL wb_ack got=%b want=1", dcache_rsp_valid); end
        total++; if (dcache_rsp_data !== PAT_BEEF) begin bad++; $display("[TB] FAIL wb_ack_data got=%h want=%h", dcache_rsp_data, PAT_BEEF); end
        mem_rsp_valid    = 1'b0;
        dcache_req_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_late_arrival();
        doReset();
        dcache_req_valid = 1'b1;
        dcache_req_info  = mkReq(32'h5000, 1'b0, '0);
        tick();
        tick();
        icache_req_valid = 1'b1;
        icache_req_info  = mkReq(32'h6000, 1'b0, '0);
        tick();
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL late_no_issue_wait got=%b want=0", mem_req_valid); end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = PAT_5A;
        tick();
        total++; if (dcache_rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL late_dc_rsp got=%b want=1", dcache_rsp_valid); end
        mem_rsp_valid    = 1'b0;
        dcache_req_valid = 1'b0;
        tick();
        total++; if (mem_req_valid !== 1'b0 || arb_busy !== 1'b1) begin
            bad++; $display("[TB] FAIL late_drain got=%b/%b want=0/1", mem_req_valid, arb_busy);
        end
        tick();
        total++; if (mem_req_valid !== 1'b0 || arb_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL late_idle got=%b/%b want=0/0", mem_req_valid, arb_busy);
        end
        tick();
        total++; if (mem_req_valid !== 1'b1 || mem_req_info.addr !== 32'h6000) begin
            bad++; $display("[TB] FAIL late_issue got=%b/%h want=1/00006000", mem_req_valid, mem_req_info.addr);
        end
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = PAT_3C;
        tick();
        total++; if (icache_rsp_data !== PAT_3C) begin bad++; $display("[TB] FAIL late_ic_data got=%h want=%h", icache_rsp_data, PAT_3C); end
        total++; if (dcache_rsp_data !== PAT_5A) begin bad++; $display("[TB] FAIL late_dc_hold got=%h want=%h", dcache_rsp_data, PAT_5A); end
        mem_rsp_valid    = 1'b0;
        icache_req_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_in_wait();
        int ic0, dc0;
        bit busySeen;
        icache_req_valid = 1'b1;
        icache_req_info  = mkReq(32'h7000, 1'b0, '0);
        tick();
        tick();
        total++; if (arb_busy !== 1'b1) begin bad++; $display("[TB] FAIL rst_wait_busy got=%b want=1", arb_busy); end
        reset = 1'b1;
        icache_req_valid = 1'b0;
        tick();
        ic0 = icRspCount; dc0 = dcRspCount;
        total++; if (arb_busy !== 1'b0 || mem_req_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL rst_wait_ctrl got=%b/%b want=0/0", arb_busy, mem_req_valid);
        end
        total++; if (mem_req_info !== '0) begin bad++; $display("[TB] FAIL rst_wait_info got=%h want=0", mem_req_info); end
        total++; if (icache_rsp_data !== '0 || dcache_rsp_data !== '0) begin
            bad++; $display("[TB] FAIL rst_wait_data got=%h/%h want=0/0", icache_rsp_data, dcache_rsp_data);
        end
        reset = 1'b0;
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = PAT_A5;
        busySeen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_rsp_valid = 1'b0;
            if (arb_busy !== 1'b0) busySeen = 1'b1;
        end
        total++; if (busySeen !== 1'b0) begin bad++; $display("[TB] FAIL rst_wait_busy_after got=1 want=0"); end
        total++; if (icRspCount - ic0 !== 0 || dcRspCount - dc0 !== 0) begin
            bad++; $display("[TB] FAIL rst_wait_pulses got=%0d/%0d want=0/0", icRspCount - ic0, dcRspCount - dc0);
        end
    endtask

    task automatic test_stray_response();
        int ic0, dc0, mr0;
        ic0 = icRspCount; dc0 = dcRspCount; mr0 = memReqCount;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = PAT_77;
        tick();
        mem_rsp_valid = 1'b0;
        tick();
        tick();
        total++; if (icRspCount - ic0 !== 0 || dcRspCount - dc0 !== 0 || memReqCount - mr0 !== 0) begin
            bad++; $display("[TB] FAIL stray_pulses got=%0d/%0d/%0d want=0/0/0", icRspCount - ic0, dcRspCount - dc0, memReqCount - mr0);
        end
        total++; if (arb_busy !== 1'b0) begin bad++; $display("[TB] FAIL stray_busy got=%b want=0", arb_busy); end
        total++; if (icache_rsp_data !== '0 || dcache_rsp_data !== '0) begin
            bad++; $display("[TB] FAIL stray_data got=%h/%h want=0/0", icache_rsp_data, dcache_rsp_data);
        end
    endtask

    // Absolute time bound so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        clearInputs();
        test_reset();
        test_single_icache();
        test_tie();
        test_writeback();
        test_late_arrival();
        test_reset_in_wait();
        test_stray_response();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
